// File: rtl/video_pkg.sv
// video_pkg: shared state encoding and stream defaults for the video-buffer padder/unpadder pair
package video_pkg;

   localparam int DATA_W_DEF  = 8;
   localparam int PAD_LEN_DEF = 16;

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      FLUSH = 2'd1,
      DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/video_unpadder_zero_run_tracker.sv
// video_unpadder_zero_run_tracker: counts held zeros, parks the byte that ends a zero run, decodes flush/terminal hits
module video_unpadder_zero_run_tracker
   import video_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PAD_LEN = PAD_LEN_DEF,
   parameter int CNT_W   = $clog2(PAD_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  state_t            state,
   input  logic              rd_valid,
   input  logic [DATA_W-1:0] rd_data,
   input  logic              out_full,
   output logic [DATA_W-1:0] pending,
   output logic              held,
   output logic              flush_hit,
   output logic              term_hit,
   output logic              hazard
);

   logic [CNT_W-1:0] zero_cnt;
   logic             is_zero;
   logic             terminal;

   // decode what the byte currently on vbuf_data will do to the stream
   always_comb begin
      is_zero   = rd_data == '0;
      held      = zero_cnt != '0;
      terminal  = zero_cnt == CNT_W'(PAD_LEN - 1);
      term_hit  = rd_valid & is_zero & terminal;
      flush_hit = rd_valid & ~is_zero & held;
      hazard    = term_hit | flush_hit;
   end

   // grow the zero run in RUN, drain it one byte per unstalled FLUSH cycle
   always_ff @(posedge clk) begin
      if (!rst) begin
         zero_cnt <= '0;
         pending  <= '0;
      end else if (clk_en) begin
         if (state == RUN && rd_valid) begin
            if (is_zero)
               zero_cnt <= terminal ? '0 : zero_cnt + CNT_W'(1);
            else if (held)
               pending <= rd_data;
         end else if (state == FLUSH && !out_full && held) begin
            zero_cnt <= zero_cnt - CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/video_unpadder.sv
// video_unpadder: strips the PAD_LEN zero tail from vbuf and forwards payload; VIDEO_UNPADDER_COUNT_EN adds byte_count
module video_unpadder
   import video_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int PAD_LEN = PAD_LEN_DEF,
   parameter int CNT_W   = $clog2(PAD_LEN)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clk_en,
   input  logic              vbuf_empty,
   output logic              vbuf_rd,
   input  logic [DATA_W-1:0] vbuf_data,
   input  logic              out_full,
   output logic              out_wr,
   output logic [DATA_W-1:0] out_data,
`ifdef VIDEO_UNPADDER_COUNT_EN
   output logic [23:0]       byte_count,
`endif
   output logic              stream_end
);

   state_t            state;
   state_t            state_nx;
   logic              rd_valid;
   logic [DATA_W-1:0] pending;
   logic              held;
   logic              flush_hit;
   logic              term_hit;
   logic              hazard;
   logic              wr;
   logic [DATA_W-1:0] wr_data;

   video_unpadder_zero_run_tracker #(
      .DATA_W  (DATA_W),
      .PAD_LEN (PAD_LEN),
      .CNT_W   (CNT_W)
   ) u_tracker (
      .clk       (clk),
      .rst       (rst),
      .clk_en    (clk_en),
      .state     (state),
      .rd_valid  (rd_valid),
      .rd_data   (vbuf_data),
      .out_full  (out_full),
      .pending   (pending),
      .held      (held),
      .flush_hit (flush_hit),
      .term_hit  (term_hit),
      .hazard    (hazard)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst)
         state <= RUN;
      else if (clk_en)
         state <= state_nx;
   end

   // leave RUN on a full tail or a run-ending byte; return once the held run and pending byte are out
   always_comb begin
      state_nx = (state == RUN && term_hit)                ? DONE  :
                 (state == RUN && flush_hit)               ? FLUSH :
                 (state == FLUSH && !out_full && !held)    ? RUN   : state;
   end

   // read issue and write selection; reads stop early so no byte lands outside RUN
   always_comb begin
      vbuf_rd = rst & clk_en & (state == RUN) & ~vbuf_empty & ~out_full & ~hazard;
      wr      = (state == RUN && rd_valid && vbuf_data != '0 && !held) ||
                (state == FLUSH && !out_full);
      wr_data = (state == FLUSH) ? (held ? '0 : pending) : vbuf_data;
   end

   // vbuf data is valid the enabled cycle after a pop
   always_ff @(posedge clk) begin
      if (!rst)
         rd_valid <= 1'b0;
      else if (clk_en)
         rd_valid <= vbuf_rd;
   end

   // registered write port and sticky end-of-stream flag
   always_ff @(posedge clk) begin
      if (!rst) begin
         out_wr     <= 1'b0;
         out_data   <= '0;
         stream_end <= 1'b0;
      end else if (clk_en) begin
         out_wr <= wr;
         if (wr)
            out_data <= wr_data;
         if (state == RUN && term_hit)
            stream_end <= 1'b1;
      end
   end

`ifdef VIDEO_UNPADDER_COUNT_EN
   // saturating count of emitted bytes; naturally frozen in DONE since nothing is written
   always_ff @(posedge clk) begin
      if (!rst)
         byte_count <= '0;
      else if (clk_en && wr && byte_count != 24'hFFFFFF)
         byte_count <= byte_count + 24'd1;
   end
`endif

endmodule

// File: tb/tb_video_unpadder.sv
// tb_video_unpadder: table-driven stream vectors plus stall and mid-flush reset sequences
module tb_video_unpadder;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       clk_en = 1'b0;
   logic       vbuf_empty;
   logic       vbuf_rd;
   logic [7:0] vbuf_data = 8'h00;
   logic       out_full = 1'b0;
   logic       out_wr;
   logic [7:0] out_data;
   logic       stream_end;
`ifdef VIDEO_UNPADDER_COUNT_EN
   logic [23:0] byte_count;
`endif

   always #5 clk = ~clk;

   video_unpadder dut (
      .clk        (clk),
      .rst        (rst),
      .clk_en     (clk_en),
      .vbuf_empty (vbuf_empty),
      .vbuf_rd    (vbuf_rd),
      .vbuf_data  (vbuf_data),
      .out_full   (out_full),
      .out_wr     (out_wr),
      .out_data   (out_data),
`ifdef VIDEO_UNPADDER_COUNT_EN
      .byte_count (byte_count),
`endif
      .stream_end (stream_end)
   );

   logic [7:0] mem [64];
   int         len = 0;
   int         ptr = 0;

   assign vbuf_empty = ptr >= len;

   always @(posedge clk) begin
      if (!rst)
         ptr <= 0;
      else if (vbuf_rd) begin
         vbuf_data <= mem[ptr];
         ptr <= ptr + 1;
      end
   end

   typedef struct {
      string           name;
      logic [3:0][7:0] ib;
      logic [3:0][7:0] ic;
      logic [3:0][7:0] ob;
      logic [3:0][7:0] oc;
      int              exp_end;
      int              exp_rd;
      int              exp_run;
      int              exp_lat;
      int              exp_endc;
   } vec_t;

   vec_t       vecs [7];
   logic [7:0] got [$];
   logic [7:0] exp_q [$];
   int         n_chk = 0;
   int         n_pass = 0;
   int         rd_cnt, first_rd, first_wr, last_wr, end_cyc, run, max_run, full_wr;

   task automatic check(input string nm, input int act, input int req);
      n_chk++;
      if (act == req)
         n_pass++;
      else
         $display("FAIL %s: got %0d expected %0d", nm, act, req);
   endtask

   task automatic load(input vec_t v);
      len = 0;
      for (int s = 3; s >= 0; s--)
         for (int k = 0; k < int'(v.ic[s]); k++) begin
            mem[len] = v.ib[s];
            len++;
         end
   endtask

   task automatic expect_from(input vec_t v);
      exp_q.delete();
      for (int s = 3; s >= 0; s--)
         for (int k = 0; k < int'(v.oc[s]); k++)
            exp_q.push_back(v.ob[s]);
   endtask

   task automatic compare_out(input string nm);
      check({nm, " n_out"}, got.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         check($sformatf("%s byte%0d", nm, i), (i < got.size()) ? int'(got[i]) : -1, int'(exp_q[i]));
   endtask

   task automatic run_stream(input string nm, input int budget, input int full_from, input int full_len, input int ce_off);
      rst = 1'b0;
      clk_en = 1'b1;
      out_full = 1'b0;
      @(posedge clk);
      #1;
      check({nm, " rst out_wr"}, int'(out_wr), 0);
      check({nm, " rst stream_end"}, int'(stream_end), 0);
      check({nm, " rst vbuf_rd"}, int'(vbuf_rd), 0);
      rst = 1'b1;
      got.delete();
      rd_cnt = 0; first_rd = -1; first_wr = -1; last_wr = -1; end_cyc = -1;
      run = 0; max_run = 0; full_wr = 0;
      for (int c = 0; c < budget; c++) begin
         clk_en = (c != ce_off);
         out_full = (c >= full_from && c < full_from + full_len);
         @(negedge clk);
         if (vbuf_rd) begin
            rd_cnt++;
            if (first_rd < 0) first_rd = c;
         end
         if (out_wr && clk_en) begin
            got.push_back(out_data);
            if (first_wr < 0) first_wr = c;
            last_wr = c;
            run++;
            if (run > max_run) max_run = run;
            if (out_full) full_wr++;
         end else if (clk_en) begin
            run = 0;
         end
         if (stream_end && end_cyc < 0) end_cyc = c;
         @(posedge clk);
         #1;
      end
      out_full = 1'b0;
      clk_en = 1'b1;
   endtask

   initial begin
      vecs[0] = '{"basic", {8'hAA,8'hBB,8'hCC,8'h00}, {8'd1,8'd1,8'd1,8'd0},
                           {8'hAA,8'hBB,8'hCC,8'h00}, {8'd1,8'd1,8'd1,8'd0}, 0, 3, 3, 2, -1};
      vecs[1] = '{"zrun",  {8'h11,8'h00,8'h22,8'h00}, {8'd1,8'd3,8'd1,8'd0},
                           {8'h11,8'h00,8'h22,8'h00}, {8'd1,8'd3,8'd1,8'd0}, 0, 5, 4, 2, -1};
      vecs[2] = '{"tail",  {8'h33,8'h00,8'h00,8'h00}, {8'd1,8'd16,8'd0,8'd0},
                           {8'h33,8'h00,8'h00,8'h00}, {8'd1,8'd0,8'd0,8'd0}, 1, 17, 1, 2, 18};
      vecs[3] = '{"z15",   {8'h00,8'h44,8'h00,8'h00}, {8'd15,8'd1,8'd16,8'd0},
                           {8'h00,8'h44,8'h00,8'h00}, {8'd15,8'd1,8'd0,8'd0}, 1, 32, 16, 18, 50};
      vecs[4] = '{"trail", {8'h55,8'h00,8'h00,8'h00}, {8'd1,8'd5,8'd0,8'd0},
                           {8'h55,8'h00,8'h00,8'h00}, {8'd1,8'd0,8'd0,8'd0}, 0, 6, 1, 2, -1};
      vecs[5] = '{"multi", {8'h01,8'h00,8'h02,8'h00}, {8'd2,8'd1,8'd1,8'd16},
                           {8'h01,8'h00,8'h02,8'h00}, {8'd2,8'd1,8'd1,8'd0}, 1, 20, 2, 2, 24};
      vecs[6] = '{"after", {8'h77,8'h00,8'h88,8'h00}, {8'd1,8'd16,8'd2,8'd0},
                           {8'h77,8'h00,8'h00,8'h00}, {8'd1,8'd0,8'd0,8'd0}, 1, 17, 1, 2, 18};

      for (int i = 0; i < 7; i++) begin
         load(vecs[i]);
         expect_from(vecs[i]);
         run_stream(vecs[i].name, 80, -1, 0, -1);
         compare_out(vecs[i].name);
         check({vecs[i].name, " stream_end"}, int'(stream_end), vecs[i].exp_end);
         check({vecs[i].name, " end_cycle"}, end_cyc, vecs[i].exp_endc);
         check({vecs[i].name, " rd_count"}, rd_cnt, vecs[i].exp_rd);
         check({vecs[i].name, " wr_run"}, max_run, vecs[i].exp_run);
         check({vecs[i].name, " latency"}, first_wr - first_rd, vecs[i].exp_lat);
`ifdef VIDEO_UNPADDER_COUNT_EN
         check({vecs[i].name, " byte_count"}, int'(byte_count), exp_q.size());
`endif
      end

      load(vecs[1]);
      expect_from(vecs[1]);
      run_stream("stall", 40, 6, 3, 7);
      compare_out("stall");
      check("stall last_wr", last_wr, 13);
      check("stall writes_under_full", int'(full_wr <= 1), 1);
      check("stall rd_count", rd_cnt, 5);

      mem[0] = 8'h11;
      for (int k = 1; k <= 5; k++) mem[k] = 8'h00;
      mem[6] = 8'h22;
      len = 7;
      run_stream("preflush", 8, -1, 0, -1);
      check("preflush n_out", got.size(), 1);
      mem[0] = 8'h66; mem[1] = 8'h00; mem[2] = 8'h77;
      len = 3;
      exp_q.delete();
      exp_q.push_back(8'h66); exp_q.push_back(8'h00); exp_q.push_back(8'h77);
      run_stream("midrst", 40, -1, 0, -1);
      compare_out("midrst");
      check("midrst stream_end", int'(stream_end), 0);
      check("midrst rd_count", rd_cnt, 3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
